// File: rtl/enable_sequence_checker.sv
// Checks the ten-strobe enable frame (P(0)..P(9)), counts good frames and captures the first violation.
// Latency: every output is registered and reflects the en_i sample from the previous edge. No backpressure: en_i is sampled every clock.
// Optional idle timeout: define ENABLE_SEQ_CHECKER_TIMEOUT_EN, otherwise timeout_o is tied low.
module enable_sequence_checker #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [9:0]       en_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [3:0]       err_step_o,
  output logic [9:0]       err_vec_o,
  output logic             timeout_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t     state;
  logic [3:0] step;

  logic             viol;
  logic             done;
  logic [3:0]       viol_step;
  logic [CNT_W-1:0] frame_base;
  logic [CNT_W-1:0] err_base;
  logic [CNT_W-1:0] frame_next;
  logic [CNT_W-1:0] err_next;

  // Step 3 is the only step where two strobes overlap.
  function automatic logic [9:0] pat(input logic [3:0] k);
    pat = (k == 4'd3) ? 10'h00C : (10'h001 << k);
  endfunction

  always_comb begin
    viol      = 1'b0;
    done      = 1'b0;
    viol_step = 4'hF;
    if (state == S_IDLE) begin
      if ((en_i != 10'h000) && (en_i != pat(4'd0))) viol = 1'b1;
    end else begin
      if (en_i == pat(step)) begin
        done = (step == 4'd9);
      end else begin
        viol      = 1'b1;
        viol_step = step;
      end
    end
  end

  // A coincident clear takes effect before the event is counted.
  always_comb begin
    frame_base = clr_i ? '0 : frame_cnt_o;
    err_base   = clr_i ? '0 : err_cnt_o;
    frame_next = (done && (frame_base != '1)) ? frame_base + 1'b1 : frame_base;
    err_next   = (viol && (err_base != '1)) ? err_base + 1'b1 : err_base;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      step         <= 4'd0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      err_o        <= 1'b0;
      err_cnt_o    <= '0;
      err_step_o   <= 4'd0;
      err_vec_o    <= 10'h000;
    end else begin
      frame_done_o <= done;
      frame_cnt_o  <= frame_next;
      err_cnt_o    <= err_next;
      err_o        <= (err_o & ~clr_i) | viol;

      if (viol && (clr_i || !err_o)) begin
        err_step_o <= viol_step;
        err_vec_o  <= en_i;
      end else if (clr_i) begin
        err_step_o <= 4'd0;
        err_vec_o  <= 10'h000;
      end

      case (state)
        S_IDLE: begin
          if (en_i == pat(4'd0)) begin
            state  <= S_RUN;
            step   <= 4'd1;
            busy_o <= 1'b1;
          end
        end
        S_RUN: begin
          if (en_i == pat(step)) begin
            if (step == 4'd9) begin
              state  <= S_IDLE;
              step   <= 4'd0;
              busy_o <= 1'b0;
            end else begin
              step <= step + 4'd1;
            end
          end else if (en_i == pat(4'd0)) begin
            // Mismatch that looks like a fresh frame start: resync instead of dropping to IDLE.
            step <= 4'd1;
          end else begin
            state  <= S_IDLE;
            step   <= 4'd0;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          step   <= 4'd0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef ENABLE_SEQ_CHECKER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC);

  logic [15:0] idle_tmr;

  // Timer parks at the limit so the flag is raised once per idle stretch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idle_tmr  <= 16'd0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= (timeout_o & ~clr_i) | (idle_tmr == TMO_LIMIT);
      if (clr_i) begin
        idle_tmr <= 16'd0;
      end else if ((state == S_IDLE) && (en_i == 10'h000)) begin
        if (idle_tmr != TMO_LIMIT) idle_tmr <= idle_tmr + 16'd1;
      end else begin
        idle_tmr <= 16'd0;
      end
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule
